// File: rtl/uart_rx_os.sv
// uart_rx_os: self-timed oversampling UART receiver with valid/ready output.
// Samples each bit mid-period off a shared i_tick, checks optional parity and
// 1 or 2 stop bits, and latches per-word status {break, overrun, frame, parity}.
// Optional feature macro: UART_RX_BREAK_EN (break detection and BREAK state).
module uart_rx_os #(
  parameter int unsigned DataLength = 8,
  parameter int unsigned Oversample = 16,
  parameter int unsigned ParityEn   = 0,
  parameter int unsigned ParityEven = 0,
  parameter int unsigned StopBits   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tick,
  input  logic                  i_rx,
  output logic [DataLength-1:0] o_data,
  output logic [3:0]            o_status,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam int unsigned TW = $clog2(Oversample);
  localparam int unsigned BW = $clog2(DataLength) + 1;
  localparam logic [TW-1:0] MidTick  = TW'(Oversample / 2 - 1);
  localparam logic [TW-1:0] EndTick  = TW'(Oversample - 1);
  localparam logic [BW-1:0] LastData = BW'(DataLength - 1);
  localparam logic [BW-1:0] LastStop = BW'(StopBits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
`ifdef UART_RX_BREAK_EN
    S_STOP,
    S_BREAK
`else
    S_STOP
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DataLength-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic [DataLength-1:0] data_q, data_d;
  logic [3:0]            status_q, status_d;
  logic                  valid_q, valid_d;

  logic rxs, fall, mid_hit, end_hit, par_exp, frame_ferr, frame_brk;
  logic complete, frame_clr, bit_sample;

  assign rxs        = sync_q[1];
  // prev_q only moves on ticks, so an edge is held until the next tick sees it
  assign fall       = prev_q & ~rxs;
  assign mid_hit    = i_tick && (tick_cnt_q == MidTick);
  assign end_hit    = i_tick && (tick_cnt_q == EndTick);
  assign par_exp    = (ParityEven != 0) ? ^shift_q : ~^shift_q;
  assign frame_ferr = ferr_q | ~rxs;

`ifdef UART_RX_BREAK_EN
  logic ones_q, ones_d;

  // Track whether any 1 was sampled in the data/parity/stop portion
  always_comb begin
    ones_d = ones_q;
    if (frame_clr) ones_d = 1'b0;
    else if (bit_sample) ones_d = ones_q | rxs;
  end

  // Break-tracking register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ones_q <= 1'b0;
    else          ones_q <= ones_d;
  end

  assign frame_brk = ~(ones_q | rxs);
`else
  assign frame_brk = 1'b0;
`endif

  // All state registers; synchroniser and edge history reset to the idle level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      sync_q     <= '1;
      prev_q     <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      status_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      status_q   <= status_d;
      valid_q    <= valid_d;
    end
  end

  // Frame FSM: bit timing, sampling, and status accumulation
  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], i_rx};
    prev_d     = i_tick ? rxs : prev_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    complete   = 1'b0;
    frame_clr  = 1'b0;
    bit_sample = 1'b0;
    if (i_tick && state_q != S_IDLE) tick_cnt_d = tick_cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (i_tick && fall) begin
          tick_cnt_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (mid_hit) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            frame_clr  = 1'b1;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (end_hit) begin
          bit_sample = 1'b1;
          tick_cnt_d = '0;
          shift_d    = {rxs, shift_q[DataLength-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            state_d   = (ParityEn != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (end_hit) begin
          bit_sample = 1'b1;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          if (rxs != par_exp) perr_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (end_hit) begin
          bit_sample = 1'b1;
          tick_cnt_d = '0;
          ferr_d     = frame_ferr;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastStop) begin
            complete = 1'b1;
`ifdef UART_RX_BREAK_EN
            state_d  = frame_brk ? S_BREAK : S_IDLE;
`else
            state_d  = S_IDLE;
`endif
          end
        end
      end
`ifdef UART_RX_BREAK_EN
      S_BREAK: begin
        if (i_tick && rxs) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output holding register: load on completion, or flag overrun if still held
  always_comb begin
    data_d   = data_q;
    status_d = status_q;
    valid_d  = valid_q;
    if (complete) begin
      if (!valid_q || i_ready) begin
        data_d   = shift_q;
        status_d = {frame_brk, 1'b0, frame_ferr, perr_q};
        valid_d  = 1'b1;
      end else begin
        status_d[2] = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d     = 1'b0;
      status_d[2] = 1'b0;
    end
  end

  assign o_data   = data_q;
  assign o_status = status_q;
  assign o_valid  = valid_q;
  assign o_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os (default, even-parity and
// two-stop-bit instances); break expectations follow UART_RX_BREAK_EN.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int unsigned OS     = 16;
  localparam int unsigned TP     = 4;        // clocks per tick
  localparam int unsigned BITCLK = OS * TP;  // clocks per bit

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic ready0 = 1'b1, ready1 = 1'b1, ready2 = 1'b1;
  logic [7:0] data0, data1, data2;
  logic [3:0] status0, status1, status2;
  logic valid0, valid1, valid2, busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;
  int v0_cnt = 0;
  int b0_cnt = 0;
  logic [7:0] qd0[$], qd1[$], qd2[$];
  logic [3:0] qs0[$], qs1[$], qs2[$];

  uart_rx_os #(.DataLength(8), .Oversample(OS)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx0),
    .o_data(data0), .o_status(status0), .o_valid(valid0),
    .i_ready(ready0), .o_busy(busy0));

  uart_rx_os #(.DataLength(8), .Oversample(OS), .ParityEn(1), .ParityEven(1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx1),
    .o_data(data1), .o_status(status1), .o_valid(valid1),
    .i_ready(ready1), .o_busy(busy1));

  uart_rx_os #(.DataLength(8), .Oversample(OS), .StopBits(2)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx2),
    .o_data(data2), .o_status(status2), .o_valid(valid2),
    .i_ready(ready2), .o_busy(busy2));

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TP - 1) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (valid0 && ready0) begin qd0.push_back(data0); qs0.push_back(status0); end
    if (valid1 && ready1) begin qd1.push_back(data1); qs1.push_back(status1); end
    if (valid2 && ready2) begin qd2.push_back(data2); qs2.push_back(status2); end
    if (valid0) v0_cnt++;
    if (busy0) b0_cnt++;
  end

  task automatic send_bit(input int unsigned dut, input logic b);
    @(posedge clk);
    #1;
    case (dut)
      0: rx0 = b;
      1: rx1 = b;
      default: rx2 = b;
    endcase
    repeat (BITCLK - 1) @(posedge clk);
  endtask

  // par < 0 means no parity bit
  task automatic send_frame(input int unsigned dut, input logic [7:0] d, input int par,
                            input logic s1, input logic s2, input int unsigned nstop);
    send_bit(dut, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(dut, d[i]);
    if (par >= 0) send_bit(dut, par[0]);
    send_bit(dut, s1);
    if (nstop == 2) send_bit(dut, s2);
  endtask

  task automatic test_reset;
    checks++; if (data0 !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data0); end
    checks++; if (status0 !== 4'h0) begin errors++; $display("FAIL reset_status got %b exp 0000", status0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (valid1 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL reset_others got valid1=%b busy2=%b exp 0 0", valid1, busy2); end
  endtask

  task automatic test_basic;
    int v_start;
    v_start = v0_cnt;
    ready0 = 1'b1;
    send_frame(0, 8'hA5, -1, 1'b1, 1'b1, 1);
    send_bit(0, 1'b1);
    checks++;
    if (qd0.size() !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", qd0.size()); end
    else begin
      logic [7:0] d; logic [3:0] s;
      d = qd0.pop_front(); s = qs0.pop_front();
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", d); end
      checks++; if (s !== 4'b0000) begin errors++; $display("FAIL basic_status got %b exp 0000", s); end
    end
    checks++; if (v0_cnt - v_start !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d exp 1", v0_cnt - v_start); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy0); end
  endtask

  task automatic test_parity;
    logic [7:0] d; logic [3:0] s;
    send_frame(1, 8'h07, 0, 1'b1, 1'b1, 1);
    send_bit(1, 1'b1);
    send_frame(1, 8'h07, 1, 1'b1, 1'b1, 1);
    send_bit(1, 1'b1);
    checks++;
    if (qd1.size() !== 2) begin errors++; $display("FAIL parity_count got %0d exp 2", qd1.size()); end
    else begin
      d = qd1.pop_front(); s = qs1.pop_front();
      checks++; if (d !== 8'h07) begin errors++; $display("FAIL parity_bad_data got %h exp 07", d); end
      checks++; if (s !== 4'b0001) begin errors++; $display("FAIL parity_bad_status got %b exp 0001", s); end
      d = qd1.pop_front(); s = qs1.pop_front();
      checks++; if (d !== 8'h07) begin errors++; $display("FAIL parity_ok_data got %h exp 07", d); end
      checks++; if (s !== 4'b0000) begin errors++; $display("FAIL parity_ok_status got %b exp 0000", s); end
    end
  endtask

  task automatic test_stop2;
    logic [7:0] d; logic [3:0] s;
    send_frame(2, 8'h3C, -1, 1'b1, 1'b0, 2);
    send_bit(2, 1'b1);
    send_bit(2, 1'b1);
    checks++;
    if (qd2.size() !== 1) begin errors++; $display("FAIL stop2_count got %0d exp 1", qd2.size()); end
    else begin
      d = qd2.pop_front(); s = qs2.pop_front();
      checks++; if (d !== 8'h3C) begin errors++; $display("FAIL stop2_data got %h exp 3c", d); end
      checks++; if (s !== 4'b0010) begin errors++; $display("FAIL stop2_status got %b exp 0010", s); end
    end
  endtask

  task automatic test_glitch;
    int b_start, v_start;
    b_start = b0_cnt;
    v_start = v0_cnt;
    @(posedge clk); #1 rx0 = 1'b0;
    repeat ((OS / 4) * TP) @(posedge clk);
    #1 rx0 = 1'b1;
    repeat (2 * BITCLK) @(posedge clk);
    checks++; if (b0_cnt - b_start !== int'(OS / 2 * TP)) begin
      errors++; $display("FAIL glitch_busy_cycles got %0d exp %0d", b0_cnt - b_start, OS / 2 * TP); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_busy_after got %b exp 0", busy0); end
    checks++; if (v0_cnt - v_start !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", v0_cnt - v_start); end
  endtask

  task automatic test_overrun;
    logic [7:0] d; logic [3:0] s;
    ready0 = 1'b0;
    send_frame(0, 8'h11, -1, 1'b1, 1'b1, 1);
    send_frame(0, 8'h22, -1, 1'b1, 1'b1, 1);
    send_bit(0, 1'b1);
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL overrun_held_valid got %b exp 1", valid0); end
    checks++; if (data0 !== 8'h11) begin errors++; $display("FAIL overrun_held_data got %h exp 11", data0); end
    checks++; if (status0 !== 4'b0100) begin errors++; $display("FAIL overrun_held_status got %b exp 0100", status0); end
    @(posedge clk); #1 ready0 = 1'b1;
    repeat (3) @(posedge clk);
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL overrun_accept_valid got %b exp 0", valid0); end
    send_frame(0, 8'h33, -1, 1'b1, 1'b1, 1);
    send_bit(0, 1'b1);
    checks++;
    if (qd0.size() !== 2) begin errors++; $display("FAIL overrun_count got %0d exp 2", qd0.size()); end
    else begin
      d = qd0.pop_front(); s = qs0.pop_front();
      checks++; if (d !== 8'h11 || s !== 4'b0100) begin
        errors++; $display("FAIL overrun_first got %h/%b exp 11/0100", d, s); end
      d = qd0.pop_front(); s = qs0.pop_front();
      checks++; if (d !== 8'h33 || s !== 4'b0000) begin
        errors++; $display("FAIL overrun_next got %h/%b exp 33/0000", d, s); end
    end
  endtask

  task automatic test_break;
    logic [7:0] d; logic [3:0] s; logic [3:0] exp_s; logic exp_busy;
`ifdef UART_RX_BREAK_EN
    exp_s = 4'b1010; exp_busy = 1'b1;
`else
    exp_s = 4'b0010; exp_busy = 1'b0;
`endif
    ready0 = 1'b1;
    for (int i = 0; i < 30; i++) send_bit(0, 1'b0);
    checks++; if (busy0 !== exp_busy) begin errors++; $display("FAIL break_busy_low got %b exp %b", busy0, exp_busy); end
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL break_busy_after got %b exp 0", busy0); end
    checks++;
    if (qd0.size() !== 1) begin errors++; $display("FAIL break_count got %0d exp 1", qd0.size()); end
    else begin
      d = qd0.pop_front(); s = qs0.pop_front();
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL break_data got %h exp 00", d); end
      checks++; if (s !== exp_s) begin errors++; $display("FAIL break_status got %b exp %b", s, exp_s); end
    end
  endtask

  task automatic test_reset_mid;
    send_bit(2, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(2, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12 * BITCLK) @(posedge clk);
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy2); end
    checks++; if (valid2 !== 1'b0 || status2 !== 4'b0000) begin
      errors++; $display("FAIL rstmid_out got valid=%b status=%b exp 0 0000", valid2, status2); end
    checks++; if (qd2.size() !== 0) begin errors++; $display("FAIL rstmid_words got %0d exp 0", qd2.size()); end
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_glitch();
    test_overrun();
    test_break();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
